// File: rtl/burst_compare_unit_if.sv
// Descriptor push channel and Avalon-MM read-beat channel of burst_compare_unit.
// master = producer of descriptors and read beats, slave = the compare unit.
interface burst_compare_unit_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 27,
  parameter int BURST_W = 11
);
  localparam int BPW = DATA_W / 8;

  logic               desc_valid_i;
  logic               desc_ready_o;
  logic [ADDR_W-1:0]  desc_addr_i;
  logic [BURST_W-1:0] desc_len_i;
  logic [BPW-1:0]     desc_start_mask_i;
  logic [BPW-1:0]     desc_end_mask_i;
  logic [7:0]         desc_ptrn_i;
  logic               desc_ptrn_type_i;
  logic               readdatavalid_i;
  logic [DATA_W-1:0]  readdata_i;

  modport master (
    output desc_valid_i, desc_addr_i, desc_len_i, desc_start_mask_i,
           desc_end_mask_i, desc_ptrn_i, desc_ptrn_type_i,
           readdatavalid_i, readdata_i,
    input  desc_ready_o
  );

  modport slave (
    input  desc_valid_i, desc_addr_i, desc_len_i, desc_start_mask_i,
           desc_end_mask_i, desc_ptrn_i, desc_ptrn_type_i,
           readdatavalid_i, readdata_i,
    output desc_ready_o
  );
endinterface

// File: rtl/burst_compare_unit.sv
// burst_compare_unit: checks Avalon-MM read bursts against a fixed or LFSR
// byte pattern, driven by a small FIFO of burst descriptors. Errors are
// reported two cycles after the offending beat as {word address, lowest
// mismatching byte lane}.
// Optional feature: define CMP_ERR_CNT_EN to add the saturating err_cnt_o.
module burst_compare_unit #(
  parameter  int DATA_W      = 128,
  parameter  int ADDR_W      = 27,
  parameter  int BURST_W     = 11,
  parameter  int DESC_DEPTH  = 4,
  localparam int BPW         = DATA_W / 8,
  localparam int BYTE_ADDR_W = (BPW > 1) ? $clog2(BPW) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_test_i,
  input  logic                          stop_on_err_i,
  burst_compare_unit_if.slave           bus,
  output logic                          busy_o,
  output logic                          err_valid_o,
  output logic [ADDR_W+BYTE_ADDR_W-1:0] err_addr_o
`ifdef CMP_ERR_CNT_EN
  ,
  output logic [31:0]                   err_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DESC_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_STOP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] len;
    logic [BPW-1:0]     smask;
    logic [BPW-1:0]     emask;
    logic [7:0]         ptrn;
    logic               ptype;
  } desc_t;

  state_t state, state_nx;

  desc_t  fifo_mem [DESC_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic   fifo_empty, fifo_full;
  desc_t  head, desc_in;

  logic [ADDR_W-1:0]  act_addr;
  logic [BURST_W-1:0] act_rem;
  logic               act_first;
  logic [BPW-1:0]     act_smask, act_emask;
  logic [7:0]         act_ptrn;
  logic               act_ptype;

  logic beat, last_beat, pop, push, load, fifo_clr, err_fire, set_stop;
  logic [BPW-1:0]         lane_mask, mis_d, mis_q;
  logic                   mis_v_q;
  logic [ADDR_W-1:0]      mis_addr_q;
  logic [BYTE_ADDR_W-1:0] low_idx;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign desc_in    = '{addr: bus.desc_addr_i, len: bus.desc_len_i,
                        smask: bus.desc_start_mask_i, emask: bus.desc_end_mask_i,
                        ptrn: bus.desc_ptrn_i, ptype: bus.desc_ptrn_type_i};

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM next state: start_test_i beats everything, then a stop on error
  always_comb begin
    state_nx = state;
    if (start_test_i) begin
      state_nx = S_IDLE;
    end else if (set_stop) begin
      state_nx = S_STOP;
    end else begin
      case (state)
        S_IDLE:  if (load) state_nx = S_BURST;
        S_BURST: if (last_beat) state_nx = load ? S_BURST : S_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // FSM outputs and handshake/control strobes
  always_comb begin
    bus.desc_ready_o = !fifo_full || (state == S_STOP);
    busy_o           = !fifo_empty || (state == S_BURST);
    beat             = (state == S_BURST) && bus.readdatavalid_i;
    last_beat        = beat && (act_rem == BURST_W'(1));
    err_fire         = mis_v_q && (|mis_q) && (state != S_STOP) && !start_test_i;
    set_stop         = err_fire && stop_on_err_i;
    fifo_clr         = start_test_i || set_stop || (state == S_STOP);
    push             = bus.desc_valid_i && bus.desc_ready_o && !fifo_clr;
    pop              = !fifo_empty && ((state == S_IDLE) || last_beat) && !fifo_clr;
    // zero-length heads are popped without ever becoming active
    load             = pop && (head.len != '0);
  end

  // Descriptor storage (data only, validity is tracked by the pointers)
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= desc_in;
  end

  // FIFO pointers, flushed on start, on stop and while stopped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Active burst slot; a load on the last beat takes priority over advancing
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_addr  <= '0;
      act_rem   <= '0;
      act_first <= 1'b0;
      act_smask <= '0;
      act_emask <= '0;
      act_ptrn  <= '0;
      act_ptype <= 1'b0;
    end else if (load) begin
      act_addr  <= head.addr;
      act_rem   <= head.len;
      act_first <= 1'b1;
      act_smask <= head.smask;
      act_emask <= head.emask;
      act_ptrn  <= head.ptrn;
      act_ptype <= head.ptype;
    end else if (beat) begin
      act_addr  <= act_addr + 1'b1;
      act_rem   <= act_rem - 1'b1;
      act_first <= 1'b0;
      if (act_ptype) act_ptrn <= {act_ptrn[6:0], act_ptrn[6] ^ act_ptrn[1] ^ act_ptrn[0]};
    end
  end

  // Per-lane enable and mismatch of the current beat
  always_comb begin
    lane_mask = '1;
    if (act_first)                 lane_mask = lane_mask & act_smask;
    if (act_rem == BURST_W'(1))    lane_mask = lane_mask & act_emask;
    mis_d = '0;
    for (int unsigned i = 0; i < BPW; i++)
      mis_d[i] = lane_mask[i] && (bus.readdata_i[8*i +: 8] != act_ptrn);
  end

  // Lowest mismatching lane of the registered beat
  always_comb begin
    low_idx = '0;
    for (int unsigned i = BPW; i > 0; i--)
      if (mis_q[i-1]) low_idx = BYTE_ADDR_W'(i - 1);
  end

  // Stage 1: register the mismatch vector and its word address
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mis_v_q    <= 1'b0;
      mis_q      <= '0;
      mis_addr_q <= '0;
    end else if (start_test_i) begin
      mis_v_q    <= 1'b0;
      mis_q      <= '0;
    end else begin
      mis_v_q    <= beat;
      mis_q      <= mis_d;
      mis_addr_q <= act_addr;
    end
  end

  // Stage 2: error strobe; the address holds between reports
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else begin
      err_valid_o <= err_fire;
      if (err_fire) err_addr_o <= {mis_addr_q, low_idx};
    end
  end

`ifdef CMP_ERR_CNT_EN
  // Saturating count of reported errors
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          err_cnt_o <= '0;
    else if (start_test_i)              err_cnt_o <= '0;
    else if (err_fire && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_burst_compare_unit.sv
// Directed bench for burst_compare_unit with DATA_W=32 (4 byte lanes).
module tb_burst_compare_unit;

  localparam int DW = 32;
  localparam int AW = 27;
  localparam int BW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_test = 1'b0;
  logic stop_on_err = 1'b0;
  logic busy, err_valid;
  logic [AW+1:0] err_addr;
`ifdef CMP_ERR_CNT_EN
  logic [31:0] err_cnt;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned beat_cyc = 0;

  logic [AW+1:0] rep_q [$];
  int unsigned   rep_cyc [$];

  burst_compare_unit_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus ();

  burst_compare_unit #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .DESC_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_test_i(start_test), .stop_on_err_i(stop_on_err),
    .bus(bus), .busy_o(busy), .err_valid_o(err_valid), .err_addr_o(err_addr)
`ifdef CMP_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err_valid) begin rep_q.push_back(err_addr); rep_cyc.push_back(cyc); end

  initial begin #2000000; $display("FAIL watchdog expired"); $fatal(1, "timeout"); end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    sm;
    logic [3:0]    em;
    logic [7:0]    p;
    logic [31:0]   data;
    logic [1:0]    exp_n;
    logic [1:0]    exp_byte;
  } vec_t;

  vec_t vt [8];

  function automatic logic [AW+1:0] ea(input logic [AW-1:0] w, input logic [1:0] b);
    return {w, b};
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    return {p[6:0], p[6] ^ p[1] ^ p[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_desc(input logic [AW-1:0] a, input logic [BW-1:0] l, input logic [3:0] sm,
                          input logic [3:0] em, input logic [7:0] p, input logic t);
    bus.desc_addr_i = a; bus.desc_len_i = l; bus.desc_start_mask_i = sm;
    bus.desc_end_mask_i = em; bus.desc_ptrn_i = p; bus.desc_ptrn_type_i = t;
  endtask

  task automatic push_desc(input logic [AW-1:0] a, input logic [BW-1:0] l, input logic [3:0] sm,
                           input logic [3:0] em, input logic [7:0] p, input logic t);
    int unsigned n = 0;
    @(negedge clk);
    set_desc(a, l, sm, em, p, t);
    bus.desc_valid_i = 1'b1;
    while (!bus.desc_ready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; failures++; $display("FAIL push_timeout actual=ready0 required=ready1"); end
    @(negedge clk);
    bus.desc_valid_i = 1'b0;
  endtask

  // Streams descriptors first..last-1 keeping desc_valid_i high; counts cycles with ready low
  task automatic stream_push(input int unsigned first, input int unsigned last, output int unsigned lows);
    int unsigned idx = first;
    int unsigned n = 0;
    lows = 0;
    while (idx < last && n < 400) begin
      @(negedge clk); n++;
      set_desc(AW'(32'h200 + 8 * idx), BW'(3), 4'hF, 4'hF, 8'(8'h10 + idx), 1'b0);
      bus.desc_valid_i = 1'b1;
      if (bus.desc_ready_o) idx++;
      else lows++;
    end
    if (idx < last) begin checks++; failures++; $display("FAIL stream_push_timeout actual=%0d required=%0d", idx, last); end
    @(negedge clk);
    bus.desc_valid_i = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d);
    @(negedge clk);
    bus.readdatavalid_i = 1'b1;
    bus.readdata_i = d;
    beat_cyc = cyc;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(negedge clk); bus.readdatavalid_i = 1'b0; end
  endtask

  task automatic pulse_start();
    @(negedge clk); start_test = 1'b1;
    @(negedge clk); start_test = 1'b0;
  endtask

  function automatic logic [31:0] sdata(input int unsigned i, input int unsigned j);
    logic [7:0] b = 8'(8'h10 + i);
    logic [31:0] d = {4{b}};
    if (i == 2 && j == 1) d[31:24] = ~b;
    if (i == 5 && j == 0) d[7:0] = ~b;
    return d;
  endfunction

  initial begin
    int unsigned lows, lows2, bc;
    logic [7:0] p;

    vt[0] = '{27'h010, 4'hF, 4'hF, 8'h5A, 32'h5A5A5A5A, 2'd0, 2'd0};
    vt[1] = '{27'h011, 4'hF, 4'hF, 8'h5A, 32'h5A5A005A, 2'd1, 2'd1};
    vt[2] = '{27'h020, 4'h3, 4'h6, 8'h3C, 32'hFF3C3CFF, 2'd0, 2'd0};
    vt[3] = '{27'h021, 4'h3, 4'h6, 8'h3C, 32'h3C3C00FF, 2'd1, 2'd1};
    vt[4] = '{27'h030, 4'hF, 4'hF, 8'h00, 32'h11000000, 2'd1, 2'd3};
    vt[5] = '{27'h031, 4'hF, 4'hF, 8'h00, 32'h00FF00FF, 2'd1, 2'd0};
    vt[6] = '{27'h040, 4'h8, 4'h1, 8'h00, 32'hFFFFFFFF, 2'd0, 2'd0};
    vt[7] = '{27'h041, 4'hC, 4'hF, 8'h99, 32'h00009999, 2'd1, 2'd2};

    bus.desc_valid_i = 1'b0; bus.readdatavalid_i = 1'b0; bus.readdata_i = '0;
    set_desc('0, '0, '0, '0, '0, 1'b0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", bus.desc_ready_o, 1);
    check("rst_busy", busy, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_addr", err_addr, 0);
`ifdef CMP_ERR_CNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    // stray beats with nothing pending are ignored
    drive_beat(32'h12345678); drive_beat(32'h0); idle(4);
    check("stray_beats_nrep", rep_q.size(), 0);
    check("stray_beats_busy", busy, 0);

    // single-word vectors
    for (int i = 0; i < 8; i++) begin
      rep_q.delete(); rep_cyc.delete();
      push_desc(vt[i].addr, BW'(1), vt[i].sm, vt[i].em, vt[i].p, 1'b0);
      drive_beat(vt[i].data);
      idle(5);
      check($sformatf("vec%0d_nrep", i), rep_q.size(), vt[i].exp_n);
      if (vt[i].exp_n == 1 && rep_q.size() == 1)
        check($sformatf("vec%0d_addr", i), rep_q[0], ea(vt[i].addr, vt[i].exp_byte));
    end

    // len 4 clean burst, busy drops right after the last beat
    rep_q.delete();
    push_desc(27'h050, BW'(4), 4'hF, 4'hF, 8'hA5, 1'b0);
    check("clean_busy_during", busy, 1);
    repeat (4) drive_beat(32'hA5A5A5A5);
    idle(1);
    check("clean_busy_after", busy, 0);
    idle(4);
    check("clean_nrep", rep_q.size(), 0);

    // len 3 at 0x100, second beat byte 2 wrong, 2-cycle latency
    rep_q.delete(); rep_cyc.delete();
    push_desc(27'h100, BW'(3), 4'hF, 4'hF, 8'hC3, 1'b0);
    drive_beat(32'hC3C3C3C3);
    drive_beat(32'hC300C3C3); bc = beat_cyc;
    drive_beat(32'hC3C3C3C3);
    idle(5);
    check("lat_nrep", rep_q.size(), 1);
    if (rep_q.size() == 1) begin
      check("lat_addr", rep_q[0], ea(27'h101, 2'd2));
      check("lat_cycles", rep_cyc[0] - bc, 2);
    end

    // LFSR seed 0x01: model sequence passes, repeated seed fails beats 2 and 3
    rep_q.delete();
    push_desc(27'h600, BW'(3), 4'hF, 4'hF, 8'h01, 1'b1);
    p = 8'h01;
    repeat (3) begin drive_beat({4{p}}); p = lfsr_next(p); end
    idle(5);
    check("lfsr_good_nrep", rep_q.size(), 0);
    rep_q.delete();
    push_desc(27'h610, BW'(3), 4'hF, 4'hF, 8'h01, 1'b1);
    repeat (3) drive_beat(32'h01010101);
    idle(5);
    check("lfsr_bad_nrep", rep_q.size(), 2);
    if (rep_q.size() == 2) begin
      check("lfsr_bad_addr0", rep_q[0], ea(27'h611, 2'd0));
      check("lfsr_bad_addr1", rep_q[1], ea(27'h612, 2'd0));
    end

    // zero-length descriptor followed by a burst wrapping the word address
    rep_q.delete();
    push_desc(27'h500, BW'(0), 4'hF, 4'hF, 8'h44, 1'b0);
    push_desc(27'h7FFFFFF, BW'(2), 4'hF, 4'hF, 8'h44, 1'b0);
    drive_beat(32'h44444444);
    drive_beat(32'h44004444);
    idle(5);
    check("wrap_nrep", rep_q.size(), 1);
    if (rep_q.size() == 1) check("wrap_addr", rep_q[0], ea(27'h0, 2'd2));
    check("wrap_busy", busy, 0);

    // back-to-back stream with desc_valid_i held
    rep_q.delete();
    stream_push(0, 5, lows);
    check("stream_no_early_full", lows, 0);
    check("stream_full_ready", bus.desc_ready_o, 0);
    check("stream_full_busy", busy, 1);
    fork
      begin
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 3; j++) drive_beat(sdata(i, j));
        idle(1);
      end
      stream_push(5, 6, lows2);
    join
    idle(6);
    check("stream_nrep", rep_q.size(), 2);
    if (rep_q.size() == 2) begin
      check("stream_addr0", rep_q[0], ea(27'h211, 2'd3));
      check("stream_addr1", rep_q[1], ea(27'h228, 2'd0));
    end
    check("stream_busy_end", busy, 0);
    check("stream_ready_end", bus.desc_ready_o, 1);

    // stop on first error, flush, discard while stopped, restart
    rep_q.delete();
    stop_on_err = 1'b1;
    push_desc(27'h300, BW'(6), 4'hF, 4'hF, 8'h77, 1'b0);
    push_desc(27'h380, BW'(2), 4'hF, 4'hF, 8'h77, 1'b0);
    for (int j = 0; j < 6; j++) drive_beat((j == 1 || j == 5) ? 32'h77770077 : 32'h77777777);
    idle(5);
    check("stop_nrep", rep_q.size(), 1);
    if (rep_q.size() == 1) check("stop_addr", rep_q[0], ea(27'h301, 2'd1));
    check("stop_busy_flushed", busy, 0);
    check("stop_ready", bus.desc_ready_o, 1);
    push_desc(27'h390, BW'(1), 4'hF, 4'hF, 8'h77, 1'b0);
    idle(2);
    check("stop_discard_busy", busy, 0);
    drive_beat(32'h00000000);
    idle(4);
    check("stop_silent_nrep", rep_q.size(), 1);
    check("stop_err_addr_held", err_addr, ea(27'h301, 2'd1));
    pulse_start();
`ifdef CMP_ERR_CNT_EN
    check("restart_err_cnt", err_cnt, 0);
`endif
    rep_q.delete();
    push_desc(27'h400, BW'(2), 4'hF, 4'hF, 8'h33, 1'b0);
    drive_beat(32'h33333333);
    drive_beat(32'h33330033);
    idle(5);
    check("restart_nrep", rep_q.size(), 1);
    if (rep_q.size() == 1) check("restart_addr", rep_q[0], ea(27'h401, 2'd1));
`ifdef CMP_ERR_CNT_EN
    check("restart_err_cnt_after", err_cnt, 1);
`endif
    stop_on_err = 1'b0;
    pulse_start();

    // asynchronous reset in the middle of a burst
    rep_q.delete();
    push_desc(27'h700, BW'(4), 4'hF, 4'hF, 8'h55, 1'b0);
    drive_beat(32'h55555555);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", bus.desc_ready_o, 1);
    check("midrst_err_addr", err_addr, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) drive_beat(32'h00000000);
    idle(5);
    check("midrst_nrep", rep_q.size(), 0);
    check("midrst_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
